stream_packer: RTL and testbench
================================

Name: stream_packer

Overview:
- Downstream neighbour of the two-entry valid/ready word buffer.
- Consumes its WORD_WIDTH stream and packs PACK_RATIO consecutive words into one wide beat.
- A beat closes early on up_last; the partial beat carries a lane-keep mask.
- Feeds wide-datapath consumers, e.g. a memory write port or a wide FIFO.

Parameters:
- WORD_WIDTH, 32, width of one input word.
- PACK_RATIO, 4, words per output beat; legal range 1..16.
- CNT_W, derived as clog2(PACK_RATIO) with a minimum of 1, lane counter width; not user-settable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- up_valid  input  1  upstream word valid.
- up_data  input  WORD_WIDTH  upstream word.
- up_last  input  1  word is the final word of a packet; closes the current beat.
- up_ready  output  1  packer accepts a word this cycle.
- down_valid  output  1  packed beat valid.
- down_data  output  WORD_WIDTH*PACK_RATIO  packed beat; lane 0 is bits [WORD_WIDTH-1:0].
- down_keep  output  PACK_RATIO  bit i set when lane i holds a real word.
- down_last  output  1  beat contains a packet's last word.
- down_ready  input  1  downstream accepts the beat.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: down_valid=0, down_data=0, down_keep=0, down_last=0, lane counter=0, accumulator=0. up_ready=1 after reset (out register empty).
- Handshakes: up transfer when up_valid & up_ready; down transfer when down_valid & down_ready.
- up_ready = ~down_valid | down_ready. This is a combinational path from down_ready and is documented. up_ready never depends on up_valid or up_last.
- Lane placement: each accepted word is written into accumulator lane[cnt] and its keep bit is set. cnt increments mod PACK_RATIO.
- Beat close: a beat closes when the accepted word has cnt==PACK_RATIO-1 or up_last=1. On close, in the same edge:
  - the out register loads {accumulator with the new word merged, keep, up_last}, and down_valid goes to 1;
  - the accumulator, keep and cnt clear to 0.
- Latency: beat visible on down_* one cycle after the closing word is accepted.
- Throughput: one word per cycle while down_ready=1. Back-to-back beats need no bubble.
- Holding rule: down_data/keep/last stay stable while down_valid & ~down_ready.
- Out register update: down_valid drops after a down transfer, unless a new beat closes on the same edge; then the new beat loads and down_valid stays 1.
- Stalling: while down_valid & ~down_ready, up_ready=0. No partial accumulation proceeds during the stall.
- Unfilled lanes: lanes of a partial beat are driven 0.
- PACK_RATIO=1: every accepted word closes a beat, giving a 1-deep registered pass-through. down_keep is always 1.
- up_last on lane PACK_RATIO-1: a single full beat with down_last=1; no extra empty beat.
- up_valid with up_ready=0: no state change.
- Reset mid-operation: any partial beat and any held out beat are discarded without emission.
- No data loss or duplication: count of words accepted equals the sum of popcount(down_keep) over emitted beats, excluding reset-discarded words.

Decomposition:
- Shared package stream_pkg:
  - clog2 function;
  - default WORD_WIDTH and PACK_RATIO constants;
  - keep-mask width helper.
- Sub-module pack_out_slice: one-entry output register with the valid/hold/load-while-drain logic, parameterised by payload width. The packer instantiates it for {data, keep, last}.
- Lane accumulator and counter stay in stream_packer.

Test Plan (WORD_WIDTH=32, PACK_RATIO=4):
- Full beats: words 0x11,0x22,0x33,0x44, no last, down_ready=1 → one beat, data 0x00000044_00000033_00000022_00000011, keep=4'b1111, last=0, down_valid rises the cycle after 0x44.
- Early close: words 0xA,0xB with up_last on 0xB → beat data 0x0..0_0000000B_0000000A, keep=4'b0011, last=1; the next word lands in lane 0.
- Backpressure: 8 words streamed, down_ready=0 for 5 cycles after the first beat → up_ready=0 while the beat is held, beat 1 stable, then both beats emitted in order with no loss.
- Streaming: 16 words, random up_valid, down_ready=1 → 4 beats, up_ready continuously 1, no bubble between closing words.
- Reset: rst asserted after 2 words of a beat, asynchronous to clk → outputs zero immediately. After release, 4 new words produce exactly one beat containing only the new words.
- PACK_RATIO=1 build: 3 words with last on word 3 → 3 beats, keep=1 each, last only on beat 3, latency 1.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared constants and elaboration-time helpers for the stream packing blocks.
package stream_pkg;

  localparam int DEF_WORD_WIDTH = 32'sd32;
  localparam int DEF_PACK_RATIO = 32'sd4;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // A single-lane packer still needs a one-bit lane counter.
  function automatic int cnt_width(input int ratio);
    int w;
    w = clog2(ratio);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

  function automatic int keep_width(input int ratio);
    return ratio;
  endfunction

endpackage

// File: rtl/pack_out_slice.sv
// One-entry output register: loads a payload, holds it under backpressure,
// and accepts a new payload on the same edge the current one drains.
module pack_out_slice
  import stream_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 can_load
);

  logic                 valid_r;
  logic [PAYLOAD_W-1:0] payload_r;

  // Combinational from out_ready so a draining beat frees the slot in the same cycle.
  assign can_load    = ~valid_r | out_ready;
  assign out_valid   = valid_r;
  assign out_payload = payload_r;

  // Valid/payload register; load has priority over drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= 1'b0;
      payload_r <= '0;
    end else if (load) begin
      valid_r   <= 1'b1;
      payload_r <= load_payload;
    end else if (out_ready) begin
      valid_r   <= 1'b0;
      payload_r <= payload_r;
    end else begin
      valid_r   <= valid_r;
      payload_r <= payload_r;
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Packs PACK_RATIO consecutive words into one wide beat; up_last closes a beat
// early and down_keep marks which lanes carry real words.
module stream_packer
  import stream_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             up_valid,
  input  logic [WORD_WIDTH-1:0]            up_data,
  input  logic                             up_last,
  output logic                             up_ready,
  output logic                             down_valid,
  output logic [WORD_WIDTH*PACK_RATIO-1:0] down_data,
  output logic [PACK_RATIO-1:0]            down_keep,
  output logic                             down_last,
  input  logic                             down_ready
);

  localparam int CNT_W     = cnt_width(PACK_RATIO);
  localparam int KEEP_W    = keep_width(PACK_RATIO);
  localparam int BEAT_W    = WORD_WIDTH * PACK_RATIO;
  localparam int PAYLOAD_W = BEAT_W + KEEP_W + 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_RATIO - 1);

  logic [BEAT_W-1:0]    acc_r;
  logic [BEAT_W-1:0]    acc_merged_s;
  logic [KEEP_W-1:0]    keep_r;
  logic [KEEP_W-1:0]    keep_merged_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 accept_s;
  logic                 close_s;
  logic                 slice_ready_s;
  logic [PAYLOAD_W-1:0] slice_payload_s;
  logic [PAYLOAD_W-1:0] out_payload_s;

  // up_ready is a combinational function of down_ready through the output slice.
  assign up_ready = slice_ready_s;
  assign accept_s = up_valid & slice_ready_s;
  assign close_s  = accept_s & ((cnt_r == LAST_LANE) | up_last);

  // Accumulator view with the incoming word already dropped into lane cnt_r.
  always_comb begin
    acc_merged_s  = acc_r;
    keep_merged_s = keep_r;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (accept_s && (cnt_r == CNT_W'(i))) begin
        acc_merged_s[i*WORD_WIDTH +: WORD_WIDTH] = up_data;
        keep_merged_s[i]                         = 1'b1;
      end else begin
        acc_merged_s[i*WORD_WIDTH +: WORD_WIDTH] = acc_r[i*WORD_WIDTH +: WORD_WIDTH];
        keep_merged_s[i]                         = keep_r[i];
      end
    end
  end

  // Lane accumulator: clears on close so unfilled lanes of the next beat read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r  <= '0;
      keep_r <= '0;
      cnt_r  <= '0;
    end else if (close_s) begin
      acc_r  <= '0;
      keep_r <= '0;
      cnt_r  <= '0;
    end else if (accept_s) begin
      acc_r  <= acc_merged_s;
      keep_r <= keep_merged_s;
      cnt_r  <= cnt_r + CNT_W'(1);
    end else begin
      acc_r  <= acc_r;
      keep_r <= keep_r;
      cnt_r  <= cnt_r;
    end
  end

  assign slice_payload_s = {acc_merged_s, keep_merged_s, up_last};

  pack_out_slice #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_out (
    .clk          (clk),
    .rst          (rst),
    .load         (close_s),
    .load_payload (slice_payload_s),
    .out_ready    (down_ready),
    .out_valid    (down_valid),
    .out_payload  (out_payload_s),
    .can_load     (slice_ready_s)
  );

  assign {down_data, down_keep, down_last} = out_payload_s;

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench: per-cycle vector table, scoreboarded beats, and
// hand-written backpressure / streaming / reset / single-lane sequences.
module tb_stream_packer;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int BW = W * R;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_valid, up_last, up_ready, down_valid, down_last, down_ready;
  logic [W-1:0]  up_data;
  logic [BW-1:0] down_data;
  logic [R-1:0]  down_keep;

  logic          up1_valid, up1_last, up1_ready, down1_valid, down1_last, down1_ready;
  logic [W-1:0]  up1_data, down1_data;
  logic [0:0]    down1_keep;

  always #5 clk = ~clk;

  stream_packer #(.WORD_WIDTH(W), .PACK_RATIO(R)) u_dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .up_data(up_data), .up_last(up_last),
    .up_ready(up_ready), .down_valid(down_valid), .down_data(down_data),
    .down_keep(down_keep), .down_last(down_last), .down_ready(down_ready)
  );

  stream_packer #(.WORD_WIDTH(W), .PACK_RATIO(1)) u_dut1 (
    .clk(clk), .rst(rst), .up_valid(up1_valid), .up_data(up1_data), .up_last(up1_last),
    .up_ready(up1_ready), .down_valid(down1_valid), .down_data(down1_data),
    .down_keep(down1_keep), .down_last(down1_last), .down_ready(down1_ready)
  );

  typedef struct {
    logic [BW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic         dr;
    logic         exp_ur;
    logic         exp_dv;
    logic [R-1:0] exp_keep;
    logic         exp_last;
  } vec_t;

  beat_t         sb_q[$];
  logic [BW-1:0] m_acc;
  logic [R-1:0]  m_keep;
  int            m_cnt;
  int            beats_seen = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_acc  = '0;
    m_keep = '0;
    m_cnt  = 0;
  endtask

  // One clock: compare any departing beat, update the reference model, land at posedge+1.
  task automatic step();
    beat_t b;
    beat_t e;
    @(negedge clk);
    if (down_valid && down_ready) begin
      beats_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", down_data);
      end else begin
        e = sb_q.pop_front();
        chk("beat_data", down_data, e.data);
        chk("beat_keep", BW'(down_keep), BW'(e.keep));
        chk("beat_last", BW'(down_last), BW'(e.last));
      end
    end
    if (up_valid && up_ready) begin
      m_acc[m_cnt*W +: W] = up_data;
      m_keep[m_cnt]       = 1'b1;
      if (m_cnt == R - 1 || up_last) begin
        b.data = m_acc;
        b.keep = m_keep;
        b.last = up_last;
        sb_q.push_back(b);
        m_acc  = '0;
        m_keep = '0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_valid"}, BW'(down_valid), BW'(0));
    chk({tag, "_data"}, down_data, BW'(0));
    chk({tag, "_keep"}, BW'(down_keep), BW'(0));
    chk({tag, "_last"}, BW'(down_last), BW'(0));
    model_reset();
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tbl[10];
    logic [BW-1:0] held;
    int            idx, stall_left, base;
    logic          stalled_once, acc;

    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[2] = '{1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[3] = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0};
    tbl[4] = '{1'b1, 32'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[5] = '{1'b1, 32'h0B, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1};
    tbl[6] = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1};
    tbl[7] = '{1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[8] = '{1'b1, 32'h0D, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1};
    tbl[9] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};

    up_valid = 1'b0; up_data = '0; up_last = 1'b0; down_ready = 1'b1;
    up1_valid = 1'b0; up1_data = '0; up1_last = 1'b0; down1_ready = 1'b1;
    model_reset();

    #12;
    chk("reset_valid", BW'(down_valid), BW'(0));
    chk("reset_data", down_data, BW'(0));
    chk("reset_keep", BW'(down_keep), BW'(0));
    chk("reset_last", BW'(down_last), BW'(0));
    chk("reset_up_ready", BW'(up_ready), BW'(1));
    chk("reset_pr1_valid", BW'(down1_valid), BW'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full beat, early close, held beat and next-word-in-lane-0.
    for (int i = 0; i < 10; i++) begin
      up_valid = tbl[i].v; up_data = tbl[i].d; up_last = tbl[i].l; down_ready = tbl[i].dr;
      #1;
      chk($sformatf("vec%0d_up_ready", i), BW'(up_ready), BW'(tbl[i].exp_ur));
      step();
      chk($sformatf("vec%0d_down_valid", i), BW'(down_valid), BW'(tbl[i].exp_dv));
      if (tbl[i].exp_dv) begin
        chk($sformatf("vec%0d_down_keep", i), BW'(down_keep), BW'(tbl[i].exp_keep));
        chk($sformatf("vec%0d_down_last", i), BW'(down_last), BW'(tbl[i].exp_last));
      end
    end
    chk("table_drained", BW'(sb_q.size()), BW'(0));

    // Backpressure: stall 5 cycles after the first beat appears.
    base = beats_seen; idx = 0; stall_left = 0; stalled_once = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && (idx < 8 || sb_q.size() > 0 || down_valid); cyc++) begin
      up_valid = (idx < 8); up_data = 32'(32'h100 + idx + 1); up_last = 1'b0;
      down_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("bp_up_ready", BW'(up_ready), BW'(0));
        chk("bp_hold_data", down_data, held);
        stall_left--;
      end
      acc = up_valid && up_ready;
      step();
      if (acc) idx++;
      if (down_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall_left   = 5;
        held         = down_data;
      end
    end
    chk("bp_stalled", BW'(stalled_once), BW'(1));
    chk("bp_words", BW'(idx), BW'(8));
    chk("bp_beats", BW'(beats_seen - base), BW'(2));
    chk("bp_drained", BW'(sb_q.size()), BW'(0));

    // Streaming with random gaps on up_valid and down_ready held high.
    base = beats_seen; idx = 0; down_ready = 1'b1; up_last = 1'b0;
    for (int cyc = 0; cyc < 300 && idx < 16; cyc++) begin
      up_valid = 1'($urandom_range(0, 1)); up_data = 32'(32'h200 + idx);
      #1;
      chk("stream_up_ready", BW'(up_ready), BW'(1));
      acc = up_valid && up_ready;
      step();
      if (acc) idx++;
    end
    up_valid = 1'b0;
    step();
    step();
    chk("stream_words", BW'(idx), BW'(16));
    chk("stream_beats", BW'(beats_seen - base), BW'(4));
    chk("stream_drained", BW'(sb_q.size()), BW'(0));

    // Reset discards a held output beat.
    up_valid = 1'b1; up_data = 32'hE0; up_last = 1'b1; down_ready = 1'b1;
    step();
    up_valid = 1'b0; up_last = 1'b0; down_ready = 1'b0;
    step();
    chk("held_before_rst", BW'(down_valid), BW'(1));
    do_reset("rst_held");
    base = beats_seen; down_ready = 1'b1;
    step();
    step();
    chk("rst_held_no_emit", BW'(beats_seen - base), BW'(0));

    // Reset discards a two-word partial beat; four new words form one clean beat.
    for (int k = 0; k < 2; k++) begin
      up_valid = 1'b1; up_data = 32'(32'hF0 + k); up_last = 1'b0;
      step();
    end
    up_valid = 1'b0;
    do_reset("rst_partial");
    base = beats_seen;
    for (int k = 0; k < 4; k++) begin
      up_valid = 1'b1; up_data = 32'(32'hF2 + k); up_last = 1'b0;
      step();
    end
    up_valid = 1'b0;
    step();
    step();
    chk("rst_partial_beats", BW'(beats_seen - base), BW'(1));
    chk("rst_partial_drained", BW'(sb_q.size()), BW'(0));

    // Single-lane build: registered pass-through, keep always 1.
    for (int k = 0; k < 3; k++) begin
      up1_valid = 1'b1; up1_data = 32'(32'h51 + k); up1_last = (k == 2); down1_ready = 1'b1;
      #1;
      chk("pr1_up_ready", BW'(up1_ready), BW'(1));
      step();
      chk($sformatf("pr1_beat%0d_valid", k), BW'(down1_valid), BW'(1));
      chk($sformatf("pr1_beat%0d_data", k), BW'(down1_data), BW'(32'h51 + k));
      chk($sformatf("pr1_beat%0d_keep", k), BW'(down1_keep), BW'(1));
      chk($sformatf("pr1_beat%0d_last", k), BW'(down1_last), BW'(k == 2));
    end
    up1_valid = 1'b0; up1_last = 1'b0;
    step();
    chk("pr1_idle_valid", BW'(down1_valid), BW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
